// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   XLEN          - datapath / address width
//   PC_INC        - sequential PC step (one 32-bit word)
//   fetch_entry_t - buffered fetch result {instr, pc, pc_plus4}
//   word_align()  - clears the byte-offset bits of an address
package fetch_stage_pkg;

   localparam int          XLEN   = 32;
   localparam logic [31:0] PC_INC = 32'd4;

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc_plus4;
   } fetch_entry_t;

   localparam int ENTRY_W = $bits(fetch_entry_t);

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
      return {a[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/adder32.sv
// Plain 32-bit adder, result modulo 2^32.
//   in1, in2 - operands
//   sum      - in1 + in2 (carry out discarded)
module adder32 (
   input  logic [31:0] in1,
   input  logic [31:0] in2,
   output logic [31:0] sum
);

   assign sum = in1 + in2;

endmodule

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO used as the fetch response buffer.
//   clk, reset   - clock, asynchronous active-high reset
//   push, data   - write an entry at the tail
//   pop          - drop the head entry
//   flush        - empty the FIFO; overrides push and pop on the same edge
//   count        - current occupancy (0..DEPTH)
//   head         - contents of the head slot (stale data when empty)
// DEPTH must be a power of 2 so the pointers wrap naturally.
// The caller guarantees no push when full unless a pop happens on the
// same edge, and no pop when empty.
module fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 96
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         data,
   input  logic                     pop,
   input  logic                     flush,
   output logic [$clog2(DEPTH):0]   count,
   output logic [WIDTH-1:0]         head
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;

   // Storage is reset so head reads as zero before anything is written.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage.
//   clk, reset          - clock, asynchronous active-high reset
//   imem_req/imem_addr  - word read to a 1-cycle-latency instruction memory
//   imem_rdata          - read data, valid the cycle after imem_req
//   redirect_valid/_target - branch/jump redirect, flushes all fetched work
//   if_valid/if_ready   - IF/ID handshake on the FIFO head
//   if_instr/if_pc/if_pc_plus4 - head entry contents
// Requests are only issued when a FIFO slot is guaranteed for the reply,
// so the memory response path never needs back-pressure.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic [XLEN-1:0] imem_rdata,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_target,
   output logic            if_valid,
   input  logic            if_ready,
   output logic [XLEN-1:0] if_instr,
   output logic [XLEN-1:0] if_pc,
   output logic [XLEN-1:0] if_pc_plus4
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] pc_seq;
   logic [XLEN-1:0] inflight_pc;
   logic [XLEN-1:0] inflight_pc4;
   logic            inflight;
   logic            squash;
   logic [CW-1:0]   occ;
   logic [CW:0]     credit;
   logic            deq;
   logic            push;
   logic [ENTRY_W-1:0] head_bits;
   fetch_entry_t    head;
   fetch_entry_t    push_entry;

   adder32 u_pc_inc (
      .in1 (pc),
      .in2 (PC_INC),
      .sum (pc_seq)
   );

   assign if_valid = (occ != '0);
   assign deq      = if_valid & if_ready;

   // Slots that will be claimed after this edge: stored entries plus the
   // reply already on its way, minus the entry leaving now.
   assign credit   = {1'b0, occ} + (CW+1)'(inflight) - (CW+1)'(deq);

   // Gated by reset so the request drops the moment reset is asserted.
   assign imem_req  = ~reset & ~redirect_valid & (credit < (CW+1)'(FIFO_DEPTH));
   assign imem_addr = pc;

   // A redirect also kills a reply landing in the same cycle; squash covers
   // the cycle after, so no pre-redirect data ever reaches the FIFO.
   assign push = inflight & ~squash & ~redirect_valid;

   assign push_entry = '{instr: imem_rdata, pc: inflight_pc, pc_plus4: inflight_pc4};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc           <= RESET_PC;
         inflight     <= 1'b0;
         inflight_pc  <= '0;
         inflight_pc4 <= '0;
         squash       <= 1'b0;
      end else begin
         squash   <= redirect_valid & inflight;
         inflight <= imem_req;
         if (redirect_valid) begin
            pc <= word_align(redirect_target);
         end else if (imem_req) begin
            pc <= pc_seq;
         end
         if (imem_req) begin
            inflight_pc  <= pc;
            inflight_pc4 <= pc_seq;
         end
      end
   end

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .data  (push_entry),
      .pop   (deq),
      .flush (redirect_valid),
      .count (occ),
      .head  (head_bits)
   );

   assign head        = head_bits;
   assign if_instr    = head.instr;
   assign if_pc       = head.pc;
   assign if_pc_plus4 = head.pc_plus4;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. Two instances share clock, reset and
// control inputs: one starting at 0x100 for the main sequence, one at
// 0xFFFF_FFF8 to watch the PC wrap. Each has a 1-cycle memory model that
// returns the bitwise inverse of the requested address.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_target = '0;
   logic        if_ready = 1'b1;

   logic        req_a, req_b, valid_a, valid_b;
   logic [31:0] addr_a, addr_b, rdata_a, rdata_b;
   logic [31:0] instr_a, instr_b, pc_a, pc_b, pc4_a, pc4_b;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   fetch_stage #(.RESET_PC(32'h0000_0100), .FIFO_DEPTH(2)) dut (
      .clk(clk), .reset(reset),
      .imem_req(req_a), .imem_addr(addr_a), .imem_rdata(rdata_a),
      .redirect_valid(redirect_valid), .redirect_target(redirect_target),
      .if_valid(valid_a), .if_ready(if_ready),
      .if_instr(instr_a), .if_pc(pc_a), .if_pc_plus4(pc4_a)
   );

   fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut_wrap (
      .clk(clk), .reset(reset),
      .imem_req(req_b), .imem_addr(addr_b), .imem_rdata(rdata_b),
      .redirect_valid(redirect_valid), .redirect_target(redirect_target),
      .if_valid(valid_b), .if_ready(if_ready),
      .if_instr(instr_b), .if_pc(pc_b), .if_pc_plus4(pc4_b)
   );

   always @(posedge clk) begin
      if (req_a) rdata_a <= ~addr_a;
      if (req_b) rdata_b <= ~addr_b;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one cycle, apply this cycle's inputs, let outputs settle.
   task automatic cyc(input logic rv, input logic [31:0] rt, input logic rdy);
      @(posedge clk);
      #1;
      redirect_valid  = rv;
      redirect_target = rt;
      if_ready        = rdy;
      #1;
   endtask

   task automatic exp_req(input string tag, input logic req, input logic [31:0] addr);
      chk({tag, ".req"}, 32'(req_a), 32'(req));
      chk({tag, ".addr"}, addr_a, addr);
   endtask

   task automatic exp_if(input string tag, input logic v, input logic [31:0] pc);
      chk({tag, ".valid"}, 32'(valid_a), 32'(v));
      if (v) begin
         chk({tag, ".pc"}, pc_a, pc);
         chk({tag, ".instr"}, instr_a, ~pc);
         chk({tag, ".pc4"}, pc4_a, pc + 32'd4);
      end
   endtask

   initial begin
      // reset state
      @(posedge clk);
      #1;
      chk("rst.req", 32'(req_a), 32'd0);
      chk("rst.valid", 32'(valid_a), 32'd0);
      chk("rst.instr", instr_a, 32'h0);
      chk("rst.pc", pc_a, 32'h0);
      chk("rst.pc4", pc4_a, 32'h0);
      chk("rst.addr", addr_a, 32'h100);
      chk("rst.wrap_addr", addr_b, 32'hFFFF_FFF8);

      // sequential fetch from reset
      @(posedge clk);
      #1; reset = 1'b0; #1;
      exp_req("c0", 1'b1, 32'h100);  exp_if("c0", 1'b0, 32'h0);
      chk("c0.wrap_addr", addr_b, 32'hFFFF_FFF8);
      cyc(1'b0, 32'h0, 1'b1);
      exp_req("c1", 1'b1, 32'h104);  exp_if("c1", 1'b0, 32'h0);
      chk("c1.wrap_addr", addr_b, 32'hFFFF_FFFC);
      cyc(1'b0, 32'h0, 1'b1);
      exp_req("c2", 1'b1, 32'h108);  exp_if("c2", 1'b1, 32'h100);
      chk("c2.wrap_addr", addr_b, 32'h0);
      chk("c2.wrap_pc", pc_b, 32'hFFFF_FFF8);
      cyc(1'b0, 32'h0, 1'b1);
      exp_req("c3", 1'b1, 32'h10C);  exp_if("c3", 1'b1, 32'h104);
      chk("c3.wrap_pc", pc_b, 32'hFFFF_FFFC);
      chk("c3.wrap_pc4", pc4_b, 32'h0);

      // stall: request stops at once, FIFO fills to 2 and holds
      cyc(1'b0, 32'h0, 1'b0);
      exp_req("c4", 1'b0, 32'h110);  exp_if("c4", 1'b1, 32'h108);
      chk("c4.wrap_pc", pc_b, 32'h0);
      chk("c4.wrap_pc4", pc4_b, 32'h4);
      for (int i = 5; i <= 8; i++) begin
         cyc(1'b0, 32'h0, 1'b0);
         exp_req($sformatf("stall%0d", i), 1'b0, 32'h110);
         exp_if($sformatf("stall%0d", i), 1'b1, 32'h108);
      end

      // release: in order, no gaps or duplicates
      cyc(1'b0, 32'h0, 1'b1);
      exp_req("c9", 1'b1, 32'h110);  exp_if("c9", 1'b1, 32'h108);
      cyc(1'b0, 32'h0, 1'b1);
      exp_req("c10", 1'b1, 32'h114); exp_if("c10", 1'b1, 32'h10C);
      cyc(1'b0, 32'h0, 1'b1);
      exp_req("c11", 1'b1, 32'h118); exp_if("c11", 1'b1, 32'h110);

      // redirect to unaligned target with a reply in flight
      cyc(1'b1, 32'h0000_2003, 1'b0);
      exp_req("c12", 1'b0, 32'h11C); exp_if("c12", 1'b1, 32'h114);
      cyc(1'b0, 32'h0, 1'b1);
      exp_req("c13", 1'b1, 32'h2000); exp_if("c13", 1'b0, 32'h0);
      cyc(1'b0, 32'h0, 1'b1);
      exp_req("c14", 1'b1, 32'h2004); exp_if("c14", 1'b0, 32'h0);
      cyc(1'b0, 32'h0, 1'b0);
      exp_req("c15", 1'b0, 32'h2008); exp_if("c15", 1'b1, 32'h2000);

      // redirect on a full FIFO while the head is consumed
      cyc(1'b1, 32'h0000_3000, 1'b1);
      exp_req("c16", 1'b0, 32'h2008); exp_if("c16", 1'b1, 32'h2000);
      cyc(1'b0, 32'h0, 1'b1);
      exp_req("c17", 1'b1, 32'h3000); exp_if("c17", 1'b0, 32'h0);
      cyc(1'b0, 32'h0, 1'b1);
      exp_req("c18", 1'b1, 32'h3004); exp_if("c18", 1'b0, 32'h0);
      cyc(1'b0, 32'h0, 1'b1);
      exp_req("c19", 1'b1, 32'h3008); exp_if("c19", 1'b1, 32'h3000);

      // back-to-back redirects, last one wins
      cyc(1'b1, 32'h0000_4000, 1'b1);
      exp_req("c20", 1'b0, 32'h300C); exp_if("c20", 1'b1, 32'h3004);
      cyc(1'b1, 32'h0000_5008, 1'b1);
      exp_req("c21", 1'b0, 32'h4000); exp_if("c21", 1'b0, 32'h0);
      cyc(1'b0, 32'h0, 1'b1);
      exp_req("c22", 1'b1, 32'h5008); exp_if("c22", 1'b0, 32'h0);
      cyc(1'b0, 32'h0, 1'b1);
      exp_req("c23", 1'b1, 32'h500C); exp_if("c23", 1'b0, 32'h0);
      cyc(1'b0, 32'h0, 1'b0);
      exp_req("c24", 1'b0, 32'h5010); exp_if("c24", 1'b1, 32'h5008);

      // asynchronous reset mid-cycle with a pending reply
      #2; reset = 1'b1; #1;
      chk("arst.req", 32'(req_a), 32'd0);
      chk("arst.valid", 32'(valid_a), 32'd0);
      chk("arst.pc", pc_a, 32'h0);
      chk("arst.addr", addr_a, 32'h100);
      @(posedge clk);
      @(posedge clk);
      #1; reset = 1'b0; if_ready = 1'b1; #1;
      exp_req("r0", 1'b1, 32'h100);  exp_if("r0", 1'b0, 32'h0);
      cyc(1'b0, 32'h0, 1'b1);
      exp_req("r1", 1'b1, 32'h104);  exp_if("r1", 1'b0, 32'h0);
      cyc(1'b0, 32'h0, 1'b1);
      exp_req("r2", 1'b1, 32'h108);  exp_if("r2", 1'b1, 32'h100);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
